// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to unsigned binary converter using reverse double dabble.
// One conversion at a time, started by an en pulse and finished with a one-cycle rdy pulse.
module bcd_to_binary #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] bcd_d_in,
  output logic [BIN_W-1:0]        bin_d_out,
  output logic                    rdy,
  output logic                    err,
  output logic                    busy
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VALIDATE = 3'd1,
    SHIFT    = 3'd2,
    ADJUST   = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WORK_W-1:0]  work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               invalid_q, invalid_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               rdy_q, rdy_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [NUM_DIGITS-1:0] digit_bad;
  logic [BCD_W-1:0]      bcd_adj;
  logic                  any_bad;

  // Per-digit range check and the independent "subtract 3 if >= 8" correction.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit            = work_q[BIN_W + 4*gi +: 4];
      assign digit_bad[gi]    = (digit > 4'd9);
      assign bcd_adj[4*gi +: 4] = (digit >= 4'd8) ? (digit - 4'd3) : digit;
    end
  endgenerate

  assign any_bad = |digit_bad;

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    invalid_d = invalid_q;
    bin_d     = bin_q;
    err_d     = err_q;
    rdy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          work_d    = {bcd_d_in, {BIN_W{1'b0}}};
          cnt_d     = '0;
          invalid_d = 1'b0;
          state_d   = VALIDATE;
        end
      end
      VALIDATE: begin
        if (any_bad) begin
          invalid_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = work_q >> 1;
        cnt_d   = cnt_q + CNT_ONE;
        state_d = ADJUST;
      end
      ADJUST: begin
        // The last pass sees an all-zero BCD field, so it changes nothing.
        work_d  = {bcd_adj, work_q[BIN_W-1:0]};
        state_d = (cnt_q == CNT_LAST) ? DONE : SHIFT;
      end
      DONE: begin
        if (invalid_q) begin
          bin_d = '0;
          err_d = 1'b1;
        end else begin
          bin_d = work_q[BIN_W-1:0];
          err_d = 1'b0;
        end
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      invalid_q <= 1'b0;
      bin_q     <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      invalid_q <= invalid_d;
      bin_q     <= bin_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bin_d_out = bin_q;
  assign rdy       = rdy_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule
